// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Shared register-file widths and the write-scheduler state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module : rf_scoreboard
// Busy bit per architectural register with one set port, one clear port and three query ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
   import rv_pkg::*;
#(
   parameter int NREGS = rv_pkg::NREGS,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr,
   input  logic [AW-1:0]    clr_addr,
   input  logic [AW-1:0]    q_rs1,
   input  logic [AW-1:0]    q_rs2,
   input  logic [AW-1:0]    q_rd,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             rd_busy,
   output logic [NREGS-1:0] busy_vec
);

   logic [NREGS-1:0] bits_q;
   logic [NREGS-1:0] bits_d;

   // Clear is applied before set so a same-cycle set of the same register wins.
   always_comb begin
      bits_d = bits_q;
      if (clr) bits_d[clr_addr] = 1'b0;
      if (set) bits_d[set_addr] = 1'b1;
      bits_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) bits_q <= '0;
      else     bits_q <= bits_d;
   end

   // Bits read back as clear while rst is held, even before the register resets.
   assign busy_vec = rst ? '0 : bits_q;
   assign rs1_busy = (q_rs1 != '0) && busy_vec[q_rs1];
   assign rs2_busy = (q_rs2 != '0) && busy_vec[q_rs2];
   assign rd_busy  = (q_rd  != '0) && busy_vec[q_rd];

endmodule

`default_nettype wire

// File: rtl/rf_write_scheduler.sv
// ============================================================================
// Module : rf_write_scheduler
// Arbitrates the single register-file write port between WB and a long-latency unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_write_scheduler
   import rv_pkg::*;
#(
   parameter int XLEN         = rv_pkg::XLEN,
   parameter int NREGS        = rv_pkg::NREGS,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  logic [$clog2(NREGS)-1:0] wb_addr,
   input  logic [XLEN-1:0]          wb_data,
   output logic                     wb_stall,
   input  logic                     lu_valid,
   input  logic [$clog2(NREGS)-1:0] lu_addr,
   input  logic [XLEN-1:0]          lu_data,
   output logic                     lu_ready,
   input  logic                     sb_set,
   input  logic [$clog2(NREGS)-1:0] sb_set_addr,
   input  logic [$clog2(NREGS)-1:0] q_rs1,
   input  logic [$clog2(NREGS)-1:0] q_rs2,
   input  logic [$clog2(NREGS)-1:0] q_rd,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic                     rd_busy,
   output logic                     rf_we,
   output logic [$clog2(NREGS)-1:0] rf_waddr,
   output logic [XLEN-1:0]          rf_wdata
);

   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FORCE_AT = CW'(STARVE_LIMIT - 1);

   state_t        state_q, state_d, state_eff;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          grant_lu;
   logic          lu_fire;
   logic [NREGS-1:0] busy_vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      // Outputs behave as IDLE during reset, whatever the state register holds.
      state_eff = rst ? IDLE : state_q;
      grant_lu  = !wb_valid;
      wb_stall  = 1'b0;

      unique case (state_eff)
         IDLE: begin
            cnt_d = '0;
            if (wb_valid && lu_valid) begin
               cnt_d   = CW'(1);
               state_d = (CW'(1) >= FORCE_AT) ? FORCE : WAIT;
            end
         end
         WAIT: begin
            if (!lu_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!wb_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d >= FORCE_AT) state_d = FORCE;
            end
         end
         FORCE: begin
            grant_lu = 1'b1;
            wb_stall = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      lu_ready = grant_lu && lu_valid;
      if (grant_lu) begin
         rf_waddr = lu_addr;
         rf_wdata = lu_data;
         rf_we    = lu_valid && (lu_addr != '0);
      end else begin
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
         rf_we    = wb_valid && (wb_addr != '0);
      end
   end

   assign lu_fire = lu_valid && lu_ready;

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set      (sb_set),
      .set_addr (sb_set_addr),
      .clr      (lu_fire),
      .clr_addr (lu_addr),
      .q_rs1    (q_rs1),
      .q_rs2    (q_rs2),
      .q_rd     (q_rd),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy),
      .busy_vec (busy_vec)
   );

   // A WB write to a register with an outstanding LU write means issue let a hazard through.
   a_wb_not_busy : assert property (@(posedge clk) disable iff (rst)
      !(wb_valid && !wb_stall && (wb_addr != '0) && busy_vec[wb_addr]));

endmodule

`default_nettype wire

// File: tb/tb_rf_write_scheduler.sv
// ============================================================================
// Module : tb_rf_write_scheduler
// Directed test of WB/LU arbitration, starvation forcing, scoreboard and x0 handling.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_write_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        lu_valid;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        sb_set;
   logic [4:0]  sb_set_addr;
   logic [4:0]  q_rs1, q_rs2, q_rd;
   logic        rs1_busy, rs2_busy, rd_busy;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_write_scheduler #(
      .XLEN         (32),
      .NREGS        (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_stall    (wb_stall),
      .lu_valid    (lu_valid),
      .lu_addr     (lu_addr),
      .lu_data     (lu_data),
      .lu_ready    (lu_ready),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .q_rs1       (q_rs1),
      .q_rs2       (q_rs2),
      .q_rd        (q_rd),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .rd_busy     (rd_busy),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs driven after this settle before the next check.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b1;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
      sb_set = 1'b0; sb_set_addr = '0;
      q_rs1 = '0; q_rs2 = '0; q_rd = '0;
      step();
      step();
      settle();
      check("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
      check("rst_rf_we",    {31'd0, rf_we},    32'd0);
      check("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
      rst = 1'b0;

      // Plain WB write lands the same cycle.
      step();
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      settle();
      check("wb_rf_we",    {31'd0, rf_we},    32'd1);
      check("wb_rf_waddr", {27'd0, rf_waddr}, 32'd5);
      check("wb_rf_wdata", rf_wdata,          32'hDEADBEEF);
      check("wb_stall0",   {31'd0, wb_stall}, 32'd0);
      step();
      wb_valid = 1'b0;

      // LU alone, after its destination was marked busy.
      sb_set = 1'b1; sb_set_addr = 5'd7;
      step();
      sb_set = 1'b0; q_rd = 5'd7;
      settle();
      check("sb7_busy", {31'd0, rd_busy}, 32'd1);
      lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h1234;
      settle();
      check("lu_ready",    {31'd0, lu_ready}, 32'd1);
      check("lu_rf_we",    {31'd0, rf_we},    32'd1);
      check("lu_rf_waddr", {27'd0, rf_waddr}, 32'd7);
      check("lu_rf_wdata", rf_wdata,          32'h1234);
      check("sb7_still",   {31'd0, rd_busy},  32'd1);
      step();
      lu_valid = 1'b0;
      settle();
      check("sb7_clear", {31'd0, rd_busy}, 32'd0);

      // Starvation: WB wins cycles 0..2, LU forced at cycle 3.
      wb_valid = 1'b1; wb_addr = 5'd3;
      lu_valid = 1'b1; lu_addr = 5'd10; lu_data = 32'h55;
      for (int i = 0; i < 3; i++) begin
         wb_data = 32'hAAAA0000 + i;
         settle();
         check($sformatf("starve_c%0d_stall", i), {31'd0, wb_stall}, 32'd0);
         check($sformatf("starve_c%0d_waddr", i), {27'd0, rf_waddr}, 32'd3);
         check($sformatf("starve_c%0d_ready", i), {31'd0, lu_ready}, 32'd0);
         step();
      end
      settle();
      check("force_stall", {31'd0, wb_stall}, 32'd1);
      check("force_ready", {31'd0, lu_ready}, 32'd1);
      check("force_waddr", {27'd0, rf_waddr}, 32'd10);
      check("force_wdata", rf_wdata,          32'h55);
      step();
      lu_valid = 1'b0;
      settle();
      check("post_force_stall", {31'd0, wb_stall}, 32'd0);
      check("post_force_waddr", {27'd0, rf_waddr}, 32'd3);
      step();
      wb_valid = 1'b0;

      // Scoreboard set/clear timing and set-wins collision.
      sb_set = 1'b1; sb_set_addr = 5'd9; q_rs1 = 5'd9;
      settle();
      check("sb9_no_bypass", {31'd0, rs1_busy}, 32'd0);
      step();
      sb_set = 1'b0;
      settle();
      check("sb9_set", {31'd0, rs1_busy}, 32'd1);
      lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
      step();
      lu_valid = 1'b0;
      settle();
      check("sb9_cleared", {31'd0, rs1_busy}, 32'd0);
      sb_set = 1'b1;
      step();
      lu_valid = 1'b1;
      step();
      sb_set = 1'b0; lu_valid = 1'b0;
      settle();
      check("sb9_set_wins", {31'd0, rs1_busy}, 32'd1);
      lu_valid = 1'b1;
      step();
      lu_valid = 1'b0;
      settle();
      check("sb9_final_clear", {31'd0, rs1_busy}, 32'd0);

      // x0: handshake completes but no write; never busy.
      lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hFFFF;
      settle();
      check("x0_lu_ready", {31'd0, lu_ready}, 32'd1);
      check("x0_rf_we",    {31'd0, rf_we},    32'd0);
      step();
      lu_valid = 1'b0;
      sb_set = 1'b1; sb_set_addr = 5'd0; q_rd = 5'd0;
      step();
      sb_set = 1'b0;
      settle();
      check("x0_rd_busy", {31'd0, rd_busy}, 32'd0);

      // Reset arriving while in FORCE.
      sb_set = 1'b1; sb_set_addr = 5'd12; q_rs2 = 5'd12;
      step();
      sb_set = 1'b0;
      settle();
      check("sb12_set", {31'd0, rs2_busy}, 32'd1);
      wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
      lu_valid = 1'b1; lu_addr = 5'd11; lu_data = 32'hB;
      step(); step(); step();
      settle();
      check("pre_rst_force", {31'd0, wb_stall}, 32'd1);
      rst = 1'b1;
      settle();
      check("rst_in_force_stall", {31'd0, wb_stall}, 32'd0);
      check("rst_in_force_busy",  {31'd0, rs2_busy}, 32'd0);
      step();
      rst = 1'b0;
      settle();
      check("after_rst_stall", {31'd0, wb_stall}, 32'd0);
      check("after_rst_waddr", {27'd0, rf_waddr}, 32'd4);
      check("after_rst_busy",  {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
      step(); step(); step();
      settle();
      check("restart_force", {31'd0, wb_stall}, 32'd1);
      step();
      wb_valid = 1'b0; lu_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
